// File: rtl/sap_prog_loader_if.sv
// Host byte stream and program-RAM write port of the SAP program loader.
// The loader takes the slave side; the host/RAM side takes the master side.
interface sap_prog_loader_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/sap_prog_loader.sv
// Loads a DEPTH-word program image into the SAP RAM, checks a trailing XOR
// checksum and keeps the CPU held in reset/halt until a good image is in place.
module sap_prog_loader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  sap_prog_loader_if.slave    bus,
  output logic                cpu_rst_n_o,
  output logic                load_hlt_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    RUN   = 3'd3,
    ERROR = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] csum_q, csum_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              cpu_rst_n_q, cpu_rst_n_d;
  logic              load_hlt_q, load_hlt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              in_ready;
  logic              hs;

  assign in_ready = (state_q == LOAD) || (state_q == CHECK);
  assign hs       = bus.in_valid && in_ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      csum_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rst_n_q <= 1'b0;
      load_hlt_q  <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      csum_q      <= csum_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      load_hlt_q  <= load_hlt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    csum_d      = csum_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_rst_n_d = cpu_rst_n_q;
    load_hlt_d  = load_hlt_q;
    busy_d      = busy_q;
    done_d      = done_q;
    err_d       = err_q;

    unique case (state_q)
      IDLE, RUN, ERROR: begin
        // Re-hold the CPU on the same edge that starts a load, before any RAM write.
        if (start_i) begin
          state_d     = LOAD;
          addr_d      = '0;
          csum_d      = '0;
          done_d      = 1'b0;
          err_d       = 1'b0;
          busy_d      = 1'b1;
          cpu_rst_n_d = 1'b0;
          load_hlt_d  = 1'b1;
        end
      end
      LOAD: begin
        if (hs) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = bus.in_data;
          csum_d      = csum_q ^ bus.in_data;
          addr_d      = addr_q + ADDR_W'(1);
          if (addr_q == ADDR_W'(DEPTH - 1)) begin
            state_d = CHECK;
          end
        end
      end
      CHECK: begin
        // The checksum byte is compared only; it never reaches the RAM.
        if (hs) begin
          busy_d = 1'b0;
          if (bus.in_data == csum_q) begin
            state_d     = RUN;
            done_d      = 1'b1;
            cpu_rst_n_d = 1'b1;
            load_hlt_d  = 1'b0;
          end else begin
            state_d = ERROR;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = in_ready;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign cpu_rst_n_o   = cpu_rst_n_q;
  assign load_hlt_o    = load_hlt_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_sap_prog_loader.sv
// Scoreboard bench for sap_prog_loader: expected RAM writes are queued as bytes
// are sent and a negedge monitor pops and compares every mem_we pulse.
module tb_sap_prog_loader;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic cpu_rst_n, load_hlt, busy, done, err;

  int checks   = 0;
  int failures = 0;
  int load_no  = 0;

  logic [11:0] exp_q[$];
  logic [11:0] mon_e;
  logic [7:0]  img [16];

  sap_prog_loader_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  sap_prog_loader #(.ADDR_W(4), .DATA_W(8), .DEPTH(16)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .bus         (bus),
    .cpu_rst_n_o (cpu_rst_n),
    .load_hlt_o  (load_hlt),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: any write pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got addr=%0d data=%02h expected no write",
                 bus.mem_addr, bus.mem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("write_addr_data", {bus.mem_addr, bus.mem_wdata}, mon_e);
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, bus.in_ready, 0);
    chk({tag, "_mem_we"}, bus.mem_we, 0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    chk({tag, "_cpu_rst_n"}, cpu_rst_n, 0);
    chk({tag, "_load_hlt"}, load_hlt, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  task automatic send_byte(input logic [7:0] d);
    int t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (!bus.in_ready && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    if (!bus.in_ready) chk("ready_timeout", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic gap(input int max_gap);
    repeat ($urandom_range(max_gap, 0)) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_cpu_rst_n", cpu_rst_n, 0);
    chk("start_load_hlt", load_hlt, 1);
    chk("start_done", done, 0);
    chk("start_err", err, 0);
    chk("start_busy", busy, 1);
    chk("start_in_ready", bus.in_ready, 1);
  endtask

  // Load img[] followed by csum; start_at >= 0 raises start during that byte.
  task automatic load_image(input logic [7:0] csum, input int max_gap, input int start_at);
    logic [7:0] x;
    bit ok;
    x = 8'h00;
    for (int i = 0; i < 16; i++) x ^= img[i];
    ok = (x == csum);
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      gap(max_gap);
      exp_q.push_back({4'(i), img[i]});
      if (i == start_at) start = 1'b1;
      send_byte(img[i]);
      start = 1'b0;
    end
    gap(max_gap);
    send_byte(csum);
    chk("all_writes_seen", exp_q.size(), 0);
    chk("end_done", done, ok ? 1 : 0);
    chk("end_err", err, ok ? 0 : 1);
    chk("end_cpu_rst_n", cpu_rst_n, ok ? 1 : 0);
    chk("end_load_hlt", load_hlt, ok ? 0 : 1);
    chk("end_busy", busy, 0);
    chk("end_in_ready", bus.in_ready, 0);
    $display("load %0d: sum=%02h csum=%02h gaps<=%0d start_at=%0d expect %s",
             load_no, x, csum, max_gap, start_at, ok ? "RUN" : "ERROR");
    load_no++;
  endtask

  initial begin
    logic [7:0] x;
    rst_n        = 1'b0;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    #12;
    check_reset_vals("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // in_valid in IDLE must not handshake; then async reset while it is held.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hAA;
    repeat (4) begin
      @(posedge clk); #1;
    end
    check_reset_vals("idle_valid");
    rst_n = 1'b0;
    #1;
    check_reset_vals("idle_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.in_valid = 1'b0;

    // Nominal image 0x00..0x0F, checksum 0x00.
    for (int i = 0; i < 16; i++) img[i] = 8'(i);
    load_image(8'h00, 0, -1);

    // Same image, wrong checksum (reload from RUN).
    load_image(8'h55, 0, -1);

    // Sparse image with random gaps, checksum 0x21.
    for (int i = 0; i < 16; i++) img[i] = 8'h00;
    img[0] = 8'h1F; img[1] = 8'h2E; img[2] = 8'hE0; img[3] = 8'hF0;
    load_image(8'h21, 3, -1);

    // Reload from RUN with start raised mid-load.
    for (int i = 0; i < 16; i++) img[i] = 8'($urandom);
    x = 8'h00;
    for (int i = 0; i < 16; i++) x ^= img[i];
    load_image(x, 1, 5);

    // Random images, checksum right or wrong at random.
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < 16; i++) img[i] = 8'($urandom);
      x = 8'h00;
      for (int i = 0; i < 16; i++) x ^= img[i];
      if ($urandom_range(1, 0) == 1) x ^= 8'($urandom_range(255, 1));
      load_image(x, 2, int'($urandom_range(15, 0)));
    end

    // Reset right after the 7th handshake, while its write is on the bus.
    for (int i = 0; i < 16; i++) img[i] = 8'($urandom);
    pulse_start();
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back({4'(i), img[i]});
      send_byte(img[i]);
    end
    chk("midrst_we_before", bus.mem_we, 1);
    chk("midrst_addr_before", bus.mem_addr, 6);
    chk("midrst_pending", exp_q.size(), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_mem_we", bus.mem_we, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", bus.in_ready, 0);
    chk("midrst_cpu_rst_n", cpu_rst_n, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    x = 8'h00;
    for (int i = 0; i < 16; i++) x ^= img[i];
    load_image(x, 1, -1);

    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("final_no_stray_writes", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sap_prog_loader.md
Name: sap_prog_loader

Overview:
- Memory writer for the SAP CPU: takes a program image byte-by-byte from a host over a valid/ready handshake.
- Writes each byte sequentially into the CPU's 16x8 program RAM through a dedicated write port.
- Verifies a trailing XOR checksum.
- Holds the CPU in reset/halt until a complete, correct image is loaded, then releases it.
- Sits between the host interface (switches/UART byte source) and the CPU's clock, reset and memory write port.

Parameters:
- ADDR_W, 4, RAM address width.
- DATA_W, 8, RAM word width.
- DEPTH, 16, words per image; must equal 2**ADDR_W.

Ports:
- clk  input  1  system clock (free-running, not the CPU's gated clock)
- rst  input  1  asynchronous, active-low reset
- start  input  1  begin a new load (level sampled each cycle)
- in_valid  input  1  host byte valid
- in_data  input  DATA_W  host byte
- in_ready  output  1  loader can accept a byte this cycle
- mem_we  output  1  RAM write strobe, one cycle per word
- mem_addr  output  ADDR_W  RAM write address
- mem_wdata  output  DATA_W  RAM write data
- cpu_rst_n  output  1  CPU reset, active-low; 0 = CPU held in reset
- load_hlt  output  1  OR'd into the CPU clock halt
- busy  output  1  loader is in LOAD or CHECK
- done  output  1  last image accepted; CPU running
- err  output  1  checksum mismatch on last image

Behaviour:
- Reset:
  - Asserting rst (rst=0) takes effect immediately. State goes to IDLE.
  - Outputs: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rst_n=0, load_hlt=1, busy=0, done=0, err=0.
  - Internal address counter and checksum accumulator clear to 0.
- States: IDLE, LOAD, CHECK, RUN, ERROR.
- All outputs are registered except in_ready. in_ready is a decode of state: 1 in LOAD and CHECK, else 0.
- A handshake occurs on a rising edge where in_valid=1 and in_ready=1.
- The host may hold data across cycles. Gaps in in_valid are allowed and do not advance anything.
- IDLE:
  - cpu_rst_n=0, load_hlt=1.
  - start=1 -> LOAD. On entry, address counter=0, checksum=0, done=0, err=0.
- LOAD:
  - busy=1, cpu_rst_n=0, load_hlt=1.
  - On each handshake of byte d at address n:
    - Next cycle: mem_we=1, mem_addr=n, mem_wdata=d.
    - checksum ^= d.
    - Counter increments, wrapping from DEPTH-1 to 0.
  - mem_we is 0 in every cycle not following a handshake. Throughput is one word per cycle.
  - After the handshake at address DEPTH-1 -> CHECK.
  - start is ignored.
- CHECK:
  - Accepts exactly one byte (the checksum). It is not written to RAM.
  - Byte == accumulated XOR of all DEPTH bytes -> RUN; else -> ERROR.
  - The final RAM write (address DEPTH-1) completes in the first CHECK cycle. This is always before the checksum decision.
- RUN:
  - busy=0, done=1, cpu_rst_n=1, load_hlt=0. These values take effect on the edge entering RUN.
  - start=1 -> LOAD. On that edge: cpu_rst_n=0, load_hlt=1, done=0. The CPU is re-held before any RAM write.
- ERROR:
  - err=1, cpu_rst_n=0, load_hlt=1, busy=0.
  - start=1 -> LOAD (clears err).
- Reset mid-LOAD/CHECK:
  - A pending write is dropped; mem_we falls to 0 asynchronously.
  - RAM contents already written are not restored. The CPU stays held until a complete reload.
- start held high across LOAD completion: RUN or ERROR is entered for exactly one cycle, then LOAD restarts. This is documented, not an error.
- in_valid while in_ready=0: ignored, no side effects.
- The checksum is plain XOR, DATA_W bits wide, with no seed.

Test Plan:
- Nominal load, no gaps:
  - Stimulus: reset; start pulse; send 0x00..0x0F back-to-back, then checksum 0x00.
  - Required: 16 mem_we pulses at addresses 0..15 with data == address. done=1 and cpu_rst_n=1 one cycle after the checksum handshake; err=0.
- Checksum mismatch:
  - Stimulus: the same image with checksum 0x55.
  - Required: all 16 writes occur; state ERROR; err=1, cpu_rst_n=0, load_hlt=1, done=0.
- Handshake gaps:
  - Stimulus: image 0x1F,0x2E,0xE0,0xF0 followed by twelve 0x00, checksum 0x21. Randomly deassert in_valid 0-3 cycles between bytes.
  - Required: exactly 16 writes in order with correct addresses/data; mem_we=0 during gaps; RUN reached.
- Reset mid-load:
  - Stimulus: assert rst after the 7th byte, while mem_we is high.
  - Required: mem_we, busy and in_ready drop to 0 immediately; cpu_rst_n=0. A subsequent full load starts at address 0.
- Reload from RUN, and start ignored in LOAD:
  - Stimulus: from RUN, pulse start; pulse start again mid-load.
  - Required: cpu_rst_n=0 and load_hlt=1 on the first edge; the second start has no effect; addresses continue without restart.
- Async reset during IDLE with in_valid=1:
  - Required: no handshake, no mem_we, all outputs at reset values.
